// File: rtl/vred_pkg.sv
// Shared definitions for the vector reduction unit: vector width, reduction
// opcodes, FSM states and the legal element widths.
package vred_pkg;

  localparam int VLEN    = 128;
  localparam int NUM_SEW = 5;

  localparam logic [7:0] SEW_8   = 8'd8;
  localparam logic [7:0] SEW_16  = 8'd16;
  localparam logic [7:0] SEW_32  = 8'd32;
  localparam logic [7:0] SEW_64  = 8'd64;
  localparam logic [7:0] SEW_128 = 8'd128;

  typedef enum logic [1:0] {
    RED_SUM  = 2'b00,
    RED_SMIN = 2'b01,
    RED_SMAX = 2'b10,
    RED_UMAX = 2'b11
  } red_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Maps an element width to log2(sew/8); 7 marks an unsupported width.
  function automatic logic [2:0] sew_code(input logic [7:0] sew);
    case (sew)
      SEW_8:   sew_code = 3'd0;
      SEW_16:  sew_code = 3'd1;
      SEW_32:  sew_code = 3'd2;
      SEW_64:  sew_code = 3'd3;
      SEW_128: sew_code = 3'd4;
      default: sew_code = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/vred_if.sv
// Handshake bundle between the vALU (master) and the reduction unit (slave).
interface vred_if #(
  parameter int VLEN = 128
);
  logic            in_valid;
  logic            in_ready;
  logic [VLEN-1:0] vec_in;
  logic [7:0]      sew;
  logic [1:0]      red_op;
  logic            out_valid;
  logic            out_ready;
  logic [VLEN-1:0] red_result;
  logic            out_err;

  modport master (
    output in_valid, vec_in, sew, red_op, out_ready,
    input  in_ready, out_valid, red_result, out_err
  );

  modport slave (
    input  in_valid, vec_in, sew, red_op, out_ready,
    output in_ready, out_valid, red_result, out_err
  );
endinterface

// File: rtl/vred_combine.sv
// One reduction step: folds an element into the accumulator at the selected
// width and returns the new accumulator already extended to VLEN bits.
module vred_combine #(
  parameter int VLEN = vred_pkg::VLEN
) (
  input  logic              [VLEN-1:0] acc,
  input  logic              [VLEN-1:0] elem,
  input  logic              [7:0]      sew,
  input  vred_pkg::red_op_e            op,
  input  logic                         first,
  output logic              [VLEN-1:0] acc_next
);
  import vred_pkg::*;

  logic [VLEN-1:0] res_w [NUM_SEW];
  logic [2:0]      code;

  assign code = sew_code(sew);

  for (genvar gi = 0; gi < NUM_SEW; gi++) begin : g_width
    localparam int W = 8 << gi;
    if (W <= VLEN) begin : g_legal
      logic [W-1:0]    a;
      logic [W-1:0]    e;
      logic [W-1:0]    pick;
      logic            fill;
      logic [VLEN-1:0] res;

      always_comb begin
        a = acc[W-1:0];
        e = elem[W-1:0];
        // The first element only needs extending, there is nothing to fold yet.
        if (first) begin
          pick = e;
        end else begin
          case (op)
            RED_SUM:  pick = a + e;
            RED_SMIN: pick = ($signed(a) < $signed(e)) ? a : e;
            RED_SMAX: pick = ($signed(a) > $signed(e)) ? a : e;
            default:  pick = (a > e) ? a : e;
          endcase
        end
        fill          = (op != RED_UMAX) & pick[W-1];
        res           = {VLEN{fill}};
        res[W-1:0]    = pick;
      end

      assign res_w[gi] = res;
    end else begin : g_absent
      assign res_w[gi] = '0;
    end
  end

  always_comb begin
    acc_next = '0;
    if (code < 3'(NUM_SEW)) begin
      acc_next = res_w[code];
    end
  end

endmodule

// File: rtl/vred_unit.sv
// Sequential vector reduction: folds one SEW-wide element per cycle into an
// accumulator and presents the extended result through a valid/ready port.
module vred_unit #(
  parameter int VLEN = vred_pkg::VLEN
) (
  input logic   clk,
  input logic   rst_n,
  vred_if.slave bus
);
  import vred_pkg::*;

  localparam int IDX_W = $clog2(VLEN / 8) + 1;

  state_e           state_reg;
  logic [VLEN-1:0]  vec_reg;
  logic [VLEN-1:0]  acc_reg;
  logic [VLEN-1:0]  result_reg;
  logic [7:0]       sew_reg;
  red_op_e          op_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] last_idx_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             err_reg;

  logic [2:0]       in_code;
  logic [2:0]       run_code;
  logic             in_sew_ok;
  logic [IDX_W-1:0] in_last_idx;
  logic [VLEN-1:0]  elem_w [NUM_SEW];
  logic [VLEN-1:0]  run_elem;
  logic [VLEN-1:0]  c_elem;
  logic [7:0]       c_sew;
  red_op_e          c_op;
  logic             c_first;
  logic [VLEN-1:0]  acc_next;

  assign in_code   = sew_code(bus.sew);
  assign run_code  = sew_code(sew_reg);
  assign in_sew_ok = (in_code < 3'(NUM_SEW)) && ((32'd8 << in_code) <= 32'(VLEN));

  always_comb begin
    in_last_idx = '0;
    if (in_sew_ok) begin
      in_last_idx = IDX_W'((VLEN >> (32'd3 + 32'(in_code))) - 1);
    end
  end

  // Element idx at every supported width; the latched SEW picks one.
  for (genvar gi = 0; gi < NUM_SEW; gi++) begin : g_elem
    localparam int W = 8 << gi;
    assign elem_w[gi] = vec_reg >> (W * int'(idx_reg));
  end

  always_comb begin
    run_elem = '0;
    if (run_code < 3'(NUM_SEW)) begin
      run_elem = elem_w[run_code];
    end
  end

  // In IDLE the combiner sees the live inputs so element 0 lands on the accept edge.
  always_comb begin
    c_first = (state_reg == IDLE);
    c_elem  = c_first ? bus.vec_in : run_elem;
    c_sew   = c_first ? bus.sew : sew_reg;
    c_op    = c_first ? red_op_e'(bus.red_op) : op_reg;
  end

  vred_combine #(
    .VLEN(VLEN)
  ) u_combine (
    .acc      (acc_reg),
    .elem     (c_elem),
    .sew      (c_sew),
    .op       (c_op),
    .first    (c_first),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      vec_reg       <= '0;
      acc_reg       <= '0;
      result_reg    <= '0;
      sew_reg       <= '0;
      op_reg        <= RED_SUM;
      idx_reg       <= '0;
      last_idx_reg  <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            in_ready_reg <= 1'b0;
            vec_reg      <= bus.vec_in;
            sew_reg      <= bus.sew;
            op_reg       <= red_op_e'(bus.red_op);
            idx_reg      <= IDX_W'(1);
            last_idx_reg <= in_last_idx;
            if (!in_sew_ok) begin
              acc_reg   <= '0;
              err_reg   <= 1'b1;
              state_reg <= DONE;
            end else begin
              acc_reg   <= acc_next;
              err_reg   <= 1'b0;
              state_reg <= (in_last_idx == '0) ? DONE : RUN;
            end
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          idx_reg <= idx_reg + 1'b1;
          if (idx_reg == last_idx_reg) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          // One cycle in DONE publishes the accumulator; then wait for the sink.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
            result_reg    <= acc_reg;
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_reg & rst_n;
  assign bus.out_valid  = out_valid_reg;
  assign bus.red_result = result_reg;
  assign bus.out_err    = err_reg;

endmodule

// File: tb/tb_vred_unit.sv
// Scoreboard bench for vred_unit: a driver queues expected results at each
// accept, a monitor pops and compares them as results appear.
module tb_vred_unit;
  localparam int VLEN = 128;

  typedef struct {
    logic [VLEN-1:0] res;
    logic            err;
    int              lat;
    int              hold;
    int              acc_cyc;
    int              id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   next_id = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vred_if #(.VLEN(VLEN)) bus ();

  vred_unit #(.VLEN(VLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [VLEN-1:0] v, input logic [7:0] s, input logic [1:0] op,
                      input logic [VLEN-1:0] er, input logic ee, input int lat,
                      input int hold, input bit push);
    exp_t e;
    int   t;
    bus.vec_in   = v;
    bus.sew      = s;
    bus.red_op   = op;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_accept", {127'd0, bus.in_ready}, 1);
    @(posedge clk);
    #1;
    if (push) begin
      e.res = er; e.err = ee; e.lat = lat; e.hold = hold; e.acc_cyc = cyc; e.id = next_id;
      q.push_back(e);
      next_id++;
    end
    // Scramble the inputs so any late sampling corrupts the result.
    bus.in_valid = 1'b0;
    bus.vec_in   = ~v;
    bus.sew      = 8'd8;
    bus.red_op   = ~op;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || bus.out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", VLEN'(q.size()), 0);
  endtask

  initial begin : monitor
    exp_t cur;
    int   hold_left;
    int   lat;
    bit   seen;
    bit   have_cur;
    seen = 0; have_cur = 0; hold_left = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid && !seen) begin
        seen = 1;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got %h with nothing pending", bus.red_result);
          hold_left = 0;
        end else begin
          cur = q.pop_front();
          have_cur = 1;
          lat = cyc - cur.acc_cyc;
          $display("txn %0d: result=%h err=%b latency=%0d", cur.id, bus.red_result, bus.out_err, lat);
          check("result", bus.red_result, cur.res);
          check("out_err", {127'd0, bus.out_err}, {127'd0, cur.err});
          check("latency", VLEN'(lat), VLEN'(cur.lat));
          hold_left = cur.hold;
        end
      end else if (bus.out_valid && have_cur) begin
        check("hold_result", bus.red_result, cur.res);
        check("hold_in_ready", {127'd0, bus.in_ready}, 0);
      end
      if (bus.out_valid) begin
        if (hold_left > 0) begin
          hold_left--;
          bus.out_ready = 1'b0;
        end else begin
          bus.out_ready = 1'b1;
        end
      end else begin
        bus.out_ready = 1'b0;
        seen = 0;
        have_cur = 0;
      end
    end
  end

  initial begin : driver
    logic [VLEN-1:0] v;
    bus.in_valid = 1'b0;
    bus.vec_in   = '0;
    bus.sew      = 8'd8;
    bus.red_op   = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {127'd0, bus.out_valid}, 0);
    check("rst_in_ready_held", {127'd0, bus.in_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {127'd0, bus.in_ready}, 1);
    check("rel_out_valid", {127'd0, bus.out_valid}, 0);
    check("rel_red_result", bus.red_result, 0);
    check("rel_out_err", {127'd0, bus.out_err}, 0);

    // Sum of sixteen 0x01 bytes.
    send({16{8'h01}}, 8'd8, 2'b00, 128'h10, 1'b0, 16, 0, 1);
    // Signed min / unsigned max over 16-bit elements.
    v = {16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h7FFF, 16'h8000, 16'h0005};
    send(v, 8'd16, 2'b01, {{112{1'b1}}, 16'h8000}, 1'b0, 8, 0, 1);
    send(v, 8'd16, 2'b11, 128'h8000, 1'b0, 8, 0, 1);
    // Single element, result held while the sink stalls.
    send(128'd5, 8'd128, 2'b10, 128'd5, 1'b0, 1, 5, 1);
    // Illegal widths, then a legal vector.
    send({16{8'hAB}}, 8'd24, 2'b00, 128'd0, 1'b1, 1, 0, 1);
    send({32'd3, 32'd2, 32'd1, 32'hFFFF_FFFF}, 8'd32, 2'b00, 128'd5, 1'b0, 4, 0, 1);
    send({16{8'h11}}, 8'd0, 2'b10, 128'd0, 1'b1, 1, 0, 1);
    send({64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE}, 8'd64, 2'b10,
         {{127{1'b1}}, 1'b0}, 1'b0, 2, 0, 1);
    v = {16{8'h20}};
    v[7:0]   = 8'h10;
    v[79:72] = 8'h80;
    send(v, 8'd8, 2'b01, {{120{1'b1}}, 8'h80}, 1'b0, 16, 2, 1);
    // Sum wraps at the element width and is then sign-extended.
    send({16{8'hFF}}, 8'd8, 2'b00, {{120{1'b1}}, 8'hF0}, 1'b0, 16, 0, 1);
    drain();

    // Abort a run at idx=7 with reset.
    send({16{8'h03}}, 8'd8, 2'b00, 128'd0, 1'b0, 16, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {127'd0, bus.out_valid}, 0);
    check("abort_in_ready", {127'd0, bus.in_ready}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_rel_in_ready", {127'd0, bus.in_ready}, 1);
    check("abort_rel_out_valid", {127'd0, bus.out_valid}, 0);
    v = {16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'hFFFF, 16'h0001};
    send(v, 8'd16, 2'b11, 128'h0000_FFFF, 1'b0, 8, 0, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vred_unit.md
VRED_UNIT -- requirements
Module: vred_unit

Interface
REQ-001 Parameter: VLEN, default 128, vector register width in bits.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 in_valid  in  1  upstream (vALU result) vector is valid.
REQ-005 in_ready  out  1  block can accept a vector.
REQ-006 vec_in  in  VLEN  packed vector from vALU reg_dest; element i at [SEW*i +: SEW].
REQ-007 SEW  in  8  element width; legal values are 8, 16, 32, 64 and 128.
REQ-008 red_op  in  2  reduction select: 00 sum, 01 signed min, 10 signed max, 11 unsigned max.
REQ-009 out_valid  out  1  result is valid.
REQ-010 out_ready  in  1  downstream accepts the result.
REQ-011 red_result  out  VLEN  reduction result, extended to VLEN bits.
REQ-012 out_err  out  1  qualified by out_valid; 1 when the accepted SEW was illegal.

Function
REQ-013 Handshake: a transfer occurs on an edge where valid and ready are both 1, on either port.
REQ-014 FSM states are IDLE, RUN and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 On an IDLE accept, latch SEW and red_op; load acc with element 0 and set idx to 1.
REQ-016 On an IDLE accept, go to RUN if N=VLEN/SEW>1, else go to DONE.
REQ-017 In RUN, each cycle combine acc with element idx and increment idx.
REQ-018 In RUN, after the cycle that processes element N-1, go to DONE.
REQ-019 Latency: out_valid rises exactly N edges after the accept edge (N=16 at SEW=8; N=1 at SEW=128).
REQ-020 Sum wraps modulo 2^SEW.
REQ-021 Min and max compare the SEW-bit elements as two's complement (ops 01, 10) or unsigned (op 11).
REQ-022 Result width: ops 00, 01 and 10 sign-extend from SEW to VLEN; op 11 zero-extends.
REQ-023 Illegal SEW (any value not in REQ-007): go straight to DONE with red_result=0 and out_err=1.
REQ-024 In DONE, red_result and out_err hold stable while out_ready=0.
REQ-025 In DONE, out_ready=1 returns the FSM to IDLE on the next edge; the next accept is possible the following cycle.
REQ-026 Input changes after the accept edge do not affect the result in progress.
REQ-027 in_valid is ignored outside IDLE; no input is queued.
REQ-028 Inputs are used only at the accept edge; the vector is held in an internal VLEN register.

Reset
REQ-029 rst_n low forces IDLE immediately, asynchronously, including mid-RUN; the partial result is discarded.
REQ-030 Reset values: in_ready=1 after release; out_valid=0; red_result=0; out_err=0; acc=0; idx=0.
REQ-031 The first accept is possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package vred_pkg holds: VLEN, the red_op encodings, the FSM state enum and the legal-SEW constants.
REQ-033 The single sub-module is vred_combine: combinational, (acc, element, SEW, op) -> next acc, including extension.
REQ-034 The top level holds the FSM, the vector and idx registers, and the element mux.

Verification
REQ-035 SEW=8, op=00, all bytes 0x01 -> red_result=0x10, out_valid exactly 16 edges after accept, out_err=0.
REQ-036 SEW=16, op=01, elements {0x0005, 0x8000, 0x7FFF, ...0x0001} -> red_result = 0xFFFF...FFFF8000 (sign-extended).
REQ-037 Same vector with op=11 -> red_result = 0x000...0008000 (zero-extended).
REQ-038 SEW=128, op=10, vec_in=5 -> out_valid 1 edge after accept; hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
REQ-039 SEW=24 -> out_valid after 1 edge, out_err=1, red_result=0; a subsequent legal vector reduces normally.
REQ-040 Assert rst_n=0 at idx=7 of an SEW=8 run -> out_valid=0 and in_ready=0 at once; in_ready=1 after release; the next accept gives the correct result.
